// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//
// Burst read controller that drains a requested number of words from a
// synchronous FIFO and presents them on a valid/ready stream. The FIFO has a
// one-cycle read latency, so words arrive one cycle after the read enable. A
// 2-entry skid buffer absorbs that latency, which allows one word per cycle
// when the stream sink is ready and no more than two words outstanding when
// the sink stalls.
//
// Ports
//   clk_i         : single clock, rising edge
//   rst_n_i       : asynchronous active-low reset (deassertion synchronized
//                   externally)
//   start_i       : burst start pulse, accepted only while idle
//   len_i         : burst length in words, sampled when start is accepted
//   fifo_empty_i  : FIFO empty flag
//   fifo_error_i  : FIFO underflow/overflow flag, folded into sticky err_o
//   fifo_rd_en_o  : FIFO read enable (combinational)
//   fifo_rdata_i  : FIFO read data, valid one cycle after fifo_rd_en_o
//   m_data_o      : stream data (head of the skid buffer)
//   m_valid_o     : stream valid
//   m_ready_i     : stream ready
//   busy_o        : burst in progress (RUN, FLUSH or DONE)
//   done_o        : one-cycle burst-complete pulse
//   rd_cnt_o      : words handed over on the stream in the current/last burst
//   err_o         : sticky FIFO error, cleared by an accepted start or reset
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             fifo_empty_i,
   input  logic             fifo_error_i,
   output logic             fifo_rd_en_o,
   input  logic [WIDTH-1:0] fifo_rdata_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [LEN_W-1:0] rd_cnt_o,
   output logic             err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] issued_q;
   logic [LEN_W-1:0] issued_inc;
   logic [LEN_W-1:0] rd_cnt_q;
   logic             err_q;

   // Skid buffer: entry 0 is always the head of the in-order queue.
   logic [WIDTH-1:0] buf_q [2];
   logic [1:0]       occ_q;
   logic             inflight_q;   // a read was issued on the previous edge

   logic             pop;
   logic             capture;
   logic             rd_en;
   logic [2:0]       level;

   // --------------------------------------------------------------------------
   // Stream side and read-issue decision
   // --------------------------------------------------------------------------
   assign m_valid_o  = (occ_q != 2'd0);
   assign m_data_o   = buf_q[0];
   assign pop        = m_valid_o & m_ready_i;
   assign capture    = inflight_q;
   assign issued_inc = issued_q + LEN_W'(1);

   // Words committed to the buffer once this cycle settles: what is held, plus
   // what is already on its way, minus what leaves now. A new read is allowed
   // only if that leaves room for the word it will bring back.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path first, so no
      // latch can be inferred.
      level = 3'd0;
      rd_en = 1'b0;
      level = {1'b0, occ_q} + {2'b00, inflight_q};
      if ((state_q == RUN) && !fifo_empty_i && (issued_q < len_q) &&
          (level < (3'd2 + {2'b00, pop}))) begin
         rd_en = 1'b1;
      end
   end

   assign fifo_rd_en_o = rd_en;

   // --------------------------------------------------------------------------
   // Control FSM and burst counters
   // --------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         len_q    <= '0;
         issued_q <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         // Handshake count saturates at the burst length.
         if (pop && (rd_cnt_q != len_q)) begin
            rd_cnt_q <= rd_cnt_q + LEN_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  len_q    <= len_i;
                  issued_q <= '0;
                  rd_cnt_q <= '0;
                  err_q    <= 1'b0;
                  state_q  <= (len_i == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (rd_en) begin
                  issued_q <= issued_inc;
                  // issued < len whenever a read is issued, so this cannot wrap.
                  if (issued_inc == len_q) begin
                     state_q <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (!inflight_q && (occ_q == 2'd0)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         // Placed last so an error on the same edge as a start still sticks.
         if (fifo_error_i) begin
            err_q <= 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Skid buffer datapath
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the buffer entries are reset because entry 0 drives m_data_o
         // directly and must read as zero out of reset.
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_en;
         case ({capture, pop})
            2'b10: begin
               // Append at the tail.
               if (occ_q == 2'd0) begin
                  buf_q[0] <= fifo_rdata_i;
               end else begin
                  buf_q[1] <= fifo_rdata_i;
               end
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               // Advance the queue; a stale entry 1 is harmless once invalid.
               buf_q[0] <= buf_q[1];
               occ_q    <= occ_q - 2'd1;
            end
            2'b11: begin
               // Simultaneous pop and capture: occupancy unchanged, order kept.
               if (occ_q == 2'd1) begin
                  buf_q[0] <= fifo_rdata_i;
               end else begin
                  buf_q[0] <= buf_q[1];
                  buf_q[1] <= fifo_rdata_i;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Status outputs, decoded from registered state
   // --------------------------------------------------------------------------
   assign busy_o   = (state_q != IDLE);
   assign done_o   = (state_q == DONE);
   assign rd_cnt_o = rd_cnt_q;
   assign err_o    = err_q;

endmodule
